// File: rtl/float_to_fix_seq_pkg.sv
`default_nettype none
// ---- float_to_fix_seq_pkg : shared types and constants for the float->fixed converter (rev 1.0) ----
package float_to_fix_seq_pkg;

  localparam int          FLT_BIAS    = 127;
  localparam int          MANT_BITS   = 23;
  localparam logic [31:0] FIX_SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] FIX_SAT_NEG = 32'h8000_0000;

  // Shift amounts span roughly -150..+136, so 10 signed bits cover every operand.
  localparam int SHW = 10;

  typedef logic signed [SHW-1:0] shamt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/float_classify.sv
`default_nettype none
// ---- float_classify : combinational decode of an IEEE-754 single into sign, mantissa, shift and special result (rev 1.0) ----
module float_classify
  import float_to_fix_seq_pkg::*;
(
  input  logic [31:0] targetnumber,
  input  logic [4:0]  fixpointpos,
  output logic        sign,
  output logic [23:0] mant,
  output logic        special,
  output logic [31:0] special_val,
  output shamt_t      shift
);

  logic [7:0] exp_field;
  logic       frac_nz;
  shamt_t     e_unb;
  shamt_t     e_plus_fp;

  always_comb begin
    sign      = targetnumber[31];
    exp_field = targetnumber[30:23];
    frac_nz   = |targetnumber[22:0];
    mant      = {1'b1, targetnumber[22:0]};
    e_unb     = shamt_t'({2'b00, exp_field}) - shamt_t'(FLT_BIAS);
    e_plus_fp = e_unb + shamt_t'({5'b00000, fixpointpos});
    shift     = e_plus_fp - shamt_t'(MANT_BITS);

    special     = 1'b0;
    special_val = 32'h0000_0000;
    // Priority matters: NaN shares the all-ones exponent with Inf but must yield zero.
    if (exp_field == 8'h00) begin
      special = 1'b1;
    end else if (exp_field == 8'hFF && frac_nz) begin
      special = 1'b1;
    end else if (exp_field == 8'hFF || e_plus_fp >= shamt_t'(31)) begin
      special     = 1'b1;
      special_val = sign ? FIX_SAT_NEG : FIX_SAT_POS;
    end else if (shift < shamt_t'(-24)) begin
      special = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_to_fix_seq.sv
`default_nettype none
// ---- float_to_fix_seq : iterative IEEE-754 single -> two's-complement fixed-point converter (rev 1.0) ----
module float_to_fix_seq
  import float_to_fix_seq_pkg::*;
#(
  parameter int SHIFTS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] targetnumber,
  input  logic [4:0]  fixpointpos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam logic [SHW-1:0] STEP = SHW'(SHIFTS_PER_CYCLE);

  state_t          state;
  logic [SHW-1:0]  cnt;
  logic [31:0]     mag;
  logic            sgn;
  logic            dir_left;
  logic            spec;
  logic [31:0]     spec_val;
  logic            released;

  logic            cls_sign;
  logic [23:0]     cls_mant;
  logic            cls_special;
  logic [31:0]     cls_special_val;
  shamt_t          cls_shift;

  logic [SHW-1:0]  n_abs;
  logic [SHW-1:0]  step;
  logic            accept;

  float_classify u_classify (
    .targetnumber (targetnumber),
    .fixpointpos  (fixpointpos),
    .sign         (cls_sign),
    .mant         (cls_mant),
    .special      (cls_special),
    .special_val  (cls_special_val),
    .shift        (cls_shift)
  );

  always_comb begin
    n_abs = cls_shift[SHW-1] ? SHW'(-cls_shift) : SHW'(cls_shift);
    step  = (cnt < STEP) ? cnt : STEP;
  end

  // The IDLE cycle right after a HOLD exit is blocked so accepts are spaced latency + 2.
  assign in_ready  = (state == ST_IDLE) && !released;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mag      <= 32'h0000_0000;
      sgn      <= 1'b0;
      dir_left <= 1'b0;
      spec     <= 1'b0;
      spec_val <= 32'h0000_0000;
      released <= 1'b0;
      result   <= 32'h0000_0000;
    end else begin
      released <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sgn      <= cls_sign;
            mag      <= {8'h00, cls_mant};
            dir_left <= !cls_shift[SHW-1];
            spec     <= cls_special;
            spec_val <= cls_special_val;
            if (cls_special || n_abs == '0) begin
              cnt   <= '0;
              state <= ST_FINISH;
            end else begin
              cnt   <= n_abs;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          mag <= dir_left ? (mag << step) : (mag >> step);
          cnt <= cnt - step;
          if (cnt == step) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          result <= spec ? spec_val : (sgn ? (~mag + 32'd1) : mag);
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            state    <= ST_IDLE;
            released <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_to_fix_seq.sv
`default_nettype none
// Self-checking bench for float_to_fix_seq: value/latency model plus directed vectors.
module tb_float_to_fix_seq;

  localparam int SPC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] targetnumber = 32'h0;
  logic [4:0]  fixpointpos = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  float_to_fix_seq #(.SHIFTS_PER_CYCLE(SPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .targetnumber (targetnumber),
    .fixpointpos  (fixpointpos),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value model: real magnitude m * 2^s truncated, saturating once it reaches 2^31.
  function automatic logic [31:0] model_res(input logic [31:0] f, input logic [4:0] fp);
    int          ex;
    int          s;
    logic [63:0] m64;
    logic [63:0] mag;
    logic [63:0] neg;
    ex  = int'(f[30:23]);
    m64 = {40'd0, 1'b1, f[22:0]};
    if (ex == 0) return 32'h0;
    if (ex == 255) begin
      if (f[22:0] != 23'd0) return 32'h0;
      return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    s = ex - 150 + int'(fp);
    if (s > 8)       mag = 64'h1_0000_0000;
    else if (s >= 0) mag = m64 << s;
    else if (s < -40) mag = 64'd0;
    else             mag = m64 >> (-s);
    if (mag >= 64'h8000_0000) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    neg = ~mag + 64'd1;
    return f[31] ? neg[31:0] : mag[31:0];
  endfunction

  function automatic int model_lat(input logic [31:0] f, input logic [4:0] fp);
    int ex;
    int s;
    int n;
    ex = int'(f[30:23]);
    if (ex == 0 || ex == 255) return 2;
    if (ex - 127 + int'(fp) >= 31) return 2;
    s = ex - 150 + int'(fp);
    if (s < -24) return 2;
    n = (s < 0) ? -s : s;
    return (n + SPC - 1) / SPC + 2;
  endfunction

  // Cycle-by-cycle compare against the model; edges are numbered by cyc after they occur.
  initial begin : compare
    bit          have_pend;
    logic [31:0] pend_res;
    int          due;
    int          rel_edge;
    int          next_edge;
    bit          exp_ov;
    bit          exp_rdy;
    have_pend = 1'b0;
    pend_res  = 32'h0;
    due       = 0;
    rel_edge  = -100;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        have_pend = 1'b0;
        rel_edge  = -100;
      end else begin
        next_edge = cyc + 1;
        exp_ov  = have_pend && (next_edge >= due);
        exp_rdy = !have_pend && (next_edge != rel_edge + 1);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("busy", 32'(busy), 32'(have_pend));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_ov) chk("model_result", result, pend_res);
        if (exp_ov && out_ready) begin
          have_pend = 1'b0;
          rel_edge  = next_edge;
        end
        if (in_valid && exp_rdy) begin
          have_pend = 1'b1;
          pend_res  = model_res(targetnumber, fixpointpos);
          due       = next_edge + model_lat(targetnumber, fixpointpos);
        end
      end
    end
  end

  // Called just after a rising edge; returns the edge number of the accept.
  task automatic issue(input logic [31:0] f, input logic [4:0] fp, output int acc, output int waited);
    targetnumber = f;
    fixpointpos  = fp;
    in_valid     = 1'b1;
    waited       = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never rose for %08h", f);
    end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    targetnumber = $urandom;
    fixpointpos  = 5'($urandom_range(31, 0));
  endtask

  task automatic run(input logic [31:0] f, input logic [4:0] fp, input logic [31:0] exp_res,
                     input int exp_lat, input int hold, input bit first_edge);
    int acc;
    int w;
    chk("pin_model_result", model_res(f, fp), exp_res);
    chk("pin_model_latency", model_lat(f, fp), exp_lat);
    out_ready = (hold == 0);
    issue(f, fp, acc, w);
    if (first_edge) chk("first_edge_accept", w, 32'd0);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: no result for %08h", f);
    end else begin
      chk("latency", cyc + 1 - acc, exp_lat);
      chk("result", result, exp_res);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_result", result, exp_res);
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (hold > 0) begin
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int          acc;
    int          w;
    int          acc_e[3];
    logic [31:0] ops_f[3];
    logic [4:0]  ops_fp[3];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    run(32'h3FC0_0000, 5'd8,  32'h0000_0180, 17, 0, 1'b1);
    run(32'hC010_0000, 5'd4,  32'hFFFF_FFDC, 20, 0, 1'b0);
    run(32'h4E80_0000, 5'd0,  32'h4000_0000,  9, 0, 1'b0);
    run(32'h5015_02F9, 5'd0,  32'h7FFF_FFFF,  2, 0, 1'b0);
    run(32'hFF80_0000, 5'd3,  32'h8000_0000,  2, 0, 1'b0);
    run(32'h7FC0_0000, 5'd5,  32'h0000_0000,  2, 0, 1'b0);
    run(32'h0000_0001, 5'd0,  32'h0000_0000,  2, 0, 1'b0);
    run(32'hCF00_0000, 5'd0,  32'h8000_0000,  2, 0, 1'b0);
    run(32'h3F80_0000, 5'd31, 32'h7FFF_FFFF,  2, 0, 1'b0);
    run(32'h3F80_0000, 5'd30, 32'h4000_0000,  9, 0, 1'b0);
    run(32'h3F80_0000, 5'd0,  32'h0000_0001, 25, 0, 1'b0);
    run(32'h3E00_0000, 5'd1,  32'h0000_0000,  2, 0, 1'b0);
    run(32'h3E80_0000, 5'd1,  32'h0000_0000, 26, 10, 1'b0);

    // Abort a conversion mid-shift with an asynchronous reset.
    out_ready = 1'b1;
    issue(32'h3FC0_0000, 5'd8, acc, w);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(32'h42C8_0000, 5'd16, 32'h0064_0000, 3, 0, 1'b1);

    // Back-to-back with in_valid held high, operand swapped after each accept.
    ops_f[0] = 32'h3FC0_0000; ops_fp[0] = 5'd8;
    ops_f[1] = 32'hFF80_0000; ops_fp[1] = 5'd0;
    ops_f[2] = 32'h4E80_0000; ops_fp[2] = 5'd0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      targetnumber = ops_f[i];
      fixpointpos  = ops_fp[i];
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
        w++;
        @(negedge clk);
      end
      if (w >= 100) begin
        checks++;
        errors++;
        $display("FAIL b2b_accept_timeout: op %0d", i);
      end
      acc_e[i] = cyc + 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("b2b_spacing_0", acc_e[1] - acc_e[0], 32'd19);
    chk("b2b_spacing_1", acc_e[2] - acc_e[1], 32'd4);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL b2b_final_timeout: last result missing");
    end else begin
      chk("b2b_last_result", result, 32'h4000_0000);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_to_fix_seq.md
FLOAT_TO_FIX_SEQ -- requirements
Module: float_to_fix_seq

Interface
REQ-001 The block SHALL have parameter SHIFTS_PER_CYCLE, default 1: mantissa bit positions shifted per SHIFT cycle; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- targetnumber  in  32  IEEE-754 single-precision operand.
- fixpointpos  in  5  number of fractional bits of the result, 0..31.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  two's-complement fixed-point value with fixpointpos fractional bits.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; targetnumber and fixpointpos are captured on that edge.
REQ-004 in_ready SHALL equal 1 only in state IDLE.
REQ-005 The states SHALL be IDLE, SHIFT, FINISH and HOLD.
- IDLE -> SHIFT on acceptance when the shift count n > 0.
- IDLE -> FINISH on acceptance when n = 0 or the operand is a special case.
- SHIFT -> FINISH when the remaining count reaches 0.
- FINISH -> HOLD.
- HOLD -> IDLE when out_ready = 1.
REQ-006 Decode: sign = bit 31, e = bits 30:23 minus 127, m = {1, bits 22:0} (24 bits).
REQ-007 Shift amount s = e - 23 + fixpointpos, computed as a signed value at least 10 bits wide.
- s > 0: left shift by s.
- s < 0: right shift by -s.
- n = |s|.
REQ-008 Each SHIFT cycle SHALL shift the 32-bit magnitude register by min(SHIFTS_PER_CYCLE, remaining) positions. Shifts are logical; bits shifted out to the right are discarded, so results truncate toward zero.
REQ-009 Special cases SHALL bypass SHIFT and produce a fixed result:
- exponent field 0 (zero or denormal): result 0x00000000.
- NaN: result 0x00000000.
- +Inf, or e + fixpointpos >= 31 with sign 0: result 0x7FFFFFFF.
- -Inf, or e + fixpointpos >= 31 with sign 1: result 0x80000000.
- s < -24 (underflow): result 0x00000000.
REQ-010 FINISH SHALL load result with the magnitude when sign = 0, or with its two's complement when sign = 1. A magnitude of 0 always gives 0x00000000.
REQ-011 out_valid SHALL be 1 exactly in HOLD. The accept-to-out_valid latency is ceil(n / SHIFTS_PER_CYCLE) + 2 cycles, and 2 cycles for special cases.
REQ-012 result SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-013 A new request SHALL NOT be accepted in the cycle in which HOLD exits. The minimum spacing between accepts is therefore latency + 2 cycles.
REQ-014 Input changes while busy = 1 SHALL have no effect on the operation in progress.

Reset
REQ-015 When rst = 0 the block SHALL immediately enter IDLE, independent of clk.
REQ-016 Reset values: in_ready = 1 (after the reset state is established), out_valid = 0, busy = 0, result = 0x00000000, shift counter = 0.
REQ-017 Reset asserted during SHIFT, FINISH or HOLD SHALL abort the operation; no result is delivered.
REQ-018 After rst deasserts, the first rising edge SHALL be able to accept a request.

Structure
REQ-019 A shared package SHALL hold:
- the state enumeration;
- constants FLT_BIAS = 127, MANT_BITS = 23, FIX_SAT_POS = 0x7FFFFFFF, FIX_SAT_NEG = 0x80000000.
REQ-020 One combinational sub-module, float_classify, SHALL decode sign, e, m, the special-case flags and s.
REQ-021 The top level SHALL contain the FSM, the shift counter, the magnitude register and the sign-application logic.
REQ-022 There SHALL be no other sub-modules.

Verification
REQ-023 0x3FC00000 (1.5), fixpointpos 8 -> result 0x00000180; out_valid 17 cycles after accept with SHIFTS_PER_CYCLE = 1, and 4 cycles with SHIFTS_PER_CYCLE = 8.
REQ-024 0xC0100000 (-2.25), fixpointpos 4 -> 0xFFFFFFDC; 0x4E800000 (2^30), fixpointpos 0 -> 0x40000000 via 7 left-shift cycles.
REQ-025 Special cases, each with out_valid 2 cycles after accept:
- 0x501502F9, fixpointpos 0 -> 0x7FFFFFFF.
- 0xFF800000 -> 0x80000000.
- 0x7FC00000 -> 0x00000000.
- 0x00000001 -> 0x00000000.
REQ-026 0x3E800000 (0.25), fixpointpos 1 -> 0x00000000 (truncation). With out_ready held 0 for 10 cycles, result and out_valid stay stable and in_ready stays 0.
REQ-027 Reset asserted mid-SHIFT -> out_valid = 0 and IDLE at once. A following request of 0x42C80000, fixpointpos 16 -> 0x00640000.
REQ-028 Back-to-back requests with in_valid held 1: each accept occurs only in IDLE, with spacing exactly latency + 2 cycles.
